// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Resolves load-use hazards, taken-branch redirects, and long stalls from the
// mul/div unit and the data-memory handshake. It drives hold (en) and bubble
// (clr) controls for every pipeline register and the PC. A watchdog bounds the
// mul/div wait, and a saturating counter accumulates PC stall cycles.
module pipe_hazard_ctrl #(
    parameter int RA_W       = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             clr_ifid,
    output logic             clr_idex,
    output logic             clr_exmem,
    output logic             clr_memwb,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MD_WAIT  = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    localparam int MDC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MDC_W-1:0] MDC_LAST = MDC_W'(MD_TIMEOUT - 1);

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]       state, state_n;
    logic             md_pend, md_pend_n;
    logic             md_ret, md_ret_n;
    logic [MDC_W-1:0] md_cnt;
    logic             wd_fire;
    logic             lu, memw;

    logic stall_c, en_ifid_c, en_idex_c, en_exmem_c;
    logic clr_ifid_c, clr_idex_c, clr_exmem_c, clr_memwb_c;

    assign lu   = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
    assign memw = mem_req && !mem_ready;

    // Mealy control decode and next-state selection, highest priority first.
    always_comb begin
        stall_c     = 1'b0;
        en_ifid_c   = 1'b0;
        en_idex_c   = 1'b0;
        en_exmem_c  = 1'b0;
        clr_ifid_c  = 1'b0;
        clr_idex_c  = 1'b0;
        clr_exmem_c = 1'b0;
        clr_memwb_c = 1'b0;
        state_n     = state;
        md_pend_n   = md_pend;
        md_ret_n    = md_ret;
        wd_fire     = 1'b0;

        if ((state == S_MEM_WAIT) || memw) begin
            // The memory wait freezes everything up to EX/MEM and bubbles into WB.
            stall_c     = 1'b1;
            en_ifid_c   = 1'b1;
            en_idex_c   = 1'b1;
            en_exmem_c  = 1'b1;
            clr_memwb_c = 1'b1;
            if (memw) begin
                state_n   = S_MEM_WAIT;
                // md_done arriving under the memory stall must not be lost.
                md_pend_n = md_pend | md_done;
                if (state != S_MEM_WAIT) begin
                    // Remember whether an MD op is still outstanding on entry.
                    md_ret_n = (state == S_MD_WAIT) || (ex_md_start && !md_done);
                end
            end else begin
                md_pend_n = 1'b0;
                state_n   = (md_pend || md_done || !md_ret) ? S_RUN : S_MD_WAIT;
            end
        end else if ((state == S_MD_WAIT) ||
                     ((state == S_RUN) && ex_md_start && !md_done)) begin
            // The mul/div op sits in EX; MEM/WB keeps draining.
            stall_c     = 1'b1;
            en_ifid_c   = 1'b1;
            en_idex_c   = 1'b1;
            clr_exmem_c = 1'b1;
            if (md_done) begin
                state_n = S_RUN;
            end else if ((state == S_MD_WAIT) && (md_cnt == MDC_LAST)) begin
                wd_fire = 1'b1;
                state_n = S_RUN;
            end else begin
                state_n = S_MD_WAIT;
            end
        end else begin
            state_n = S_RUN;
            if ((state == S_RUN) && ex_branch_taken) begin
                // Both younger instructions are wrong-path; any load-use match is moot.
                clr_ifid_c = 1'b1;
                clr_idex_c = 1'b1;
            end else if ((state == S_RUN) && lu) begin
                stall_c    = 1'b1;
                en_ifid_c  = 1'b1;
                clr_idex_c = 1'b1;
            end
        end
    end

    // FSM, watchdog, stall counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            md_pend   <= 1'b0;
            md_ret    <= 1'b0;
            md_cnt    <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state   <= state_n;
            md_pend <= md_pend_n;
            md_ret  <= md_ret_n;
            md_cnt  <= (state == S_MD_WAIT) ? md_cnt + 1'b1 : '0;
            if (stall_c) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (wd_fire || (ex_md_start && ex_branch_taken)) begin
                err <= 1'b1;
            end
        end
    end

    assign stall_pc  = rst & stall_c;
    assign en_ifid   = rst & en_ifid_c;
    assign en_idex   = rst & en_idex_c;
    assign en_exmem  = rst & en_exmem_c;
    assign en_memwb  = 1'b0;
    assign clr_ifid  = rst & clr_ifid_c;
    assign clr_idex  = rst & clr_idex_c;
    assign clr_exmem = rst & clr_exmem_c;
    assign clr_memwb = rst & clr_memwb_c;
    assign state_o   = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push the expected
// control word, state, stall count and err into a queue; a monitor pops and
// compares once per cycle on the falling clock edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        ex_mem_read, ex_branch_taken, ex_md_start, md_done;
    logic        mem_req, mem_ready;
    logic        stall_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic        clr_ifid, clr_idex, clr_exmem, clr_memwb;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt;
    logic        err;

    // Control word order: stall_pc, en_ifid, en_idex, en_exmem, en_memwb,
    // clr_ifid, clr_idex, clr_exmem, clr_memwb.
    localparam logic [8:0] C0   = 9'b0_0000_0000;
    localparam logic [8:0] CLU  = 9'b1_1000_0100;
    localparam logic [8:0] CBR  = 9'b0_0000_1100;
    localparam logic [8:0] CMD  = 9'b1_1100_0010;
    localparam logic [8:0] CMEM = 9'b1_1110_0001;

    typedef struct packed {
        logic [8:0]  c;
        logic [1:0]  s;
        logic [31:0] n;
        logic        e;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   nchk  = 0;
    int   npass = 0;
    int   tagn  = 0;

    pipe_hazard_ctrl #(.RA_W(5), .MD_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .en_ifid(en_ifid), .en_idex(en_idex),
        .en_exmem(en_exmem), .en_memwb(en_memwb),
        .clr_ifid(clr_ifid), .clr_idex(clr_idex),
        .clr_exmem(clr_exmem), .clr_memwb(clr_memwb),
        .state_o(state_o), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctl_now();
        return {stall_pc, en_ifid, en_idex, en_exmem, en_memwb,
                clr_ifid, clr_idex, clr_exmem, clr_memwb};
    endfunction

    task automatic chk(input string nm, input int tag,
                       input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got === want) npass++;
        else $display("FAIL %s step%0d got %0h want %0h", nm, tag, got, want);
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_md_start = 1'b0; md_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic step(input logic [8:0] c, input logic [1:0] s,
                        input logic [31:0] n, input logic e);
        exp_t x;
        x.c = c; x.s = s; x.n = n; x.e = e; x.tag = tagn;
        tagn++;
        q.push_back(x);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic lu_rs1(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("ctl",   x.tag, 32'(ctl_now()), 32'(x.c));
            chk("state", x.tag, 32'(state_o),   32'(x.s));
            chk("cnt",   x.tag, stall_cnt,      x.n);
            chk("err",   x.tag, 32'(err),       32'(x.e));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        // Active hazard inputs must be masked while reset is held.
        lu_rs1(5'd5);
        #1;
        chk("rst_ctl",   -1, 32'(ctl_now()), 32'(C0));
        chk("rst_state", -1, 32'(state_o),   32'd0);
        chk("rst_cnt",   -1, stall_cnt,      32'd0);
        chk("rst_err",   -1, 32'(err),       32'd0);
        idle();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;

        // Load-use on rs1, then rs2, then a non-used match, then x0.
        lu_rs1(5'd5);                         step(CLU, 2'd0, 32'd0, 1'b0);
                                              step(C0,  2'd0, 32'd1, 1'b0);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                                              step(CLU, 2'd0, 32'd1, 1'b0);
                                              step(C0,  2'd0, 32'd2, 1'b0);
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
                                              step(C0,  2'd0, 32'd2, 1'b0);
        lu_rs1(5'd0);                         step(C0,  2'd0, 32'd2, 1'b0);

        // Branch beats a simultaneous load-use.
        lu_rs1(5'd5); ex_branch_taken = 1'b1; step(CBR, 2'd0, 32'd2, 1'b0);
                                              step(C0,  2'd0, 32'd2, 1'b0);

        // Mul/div with md_done four cycles after start.
        ex_md_start = 1'b1;                   step(CMD, 2'd0, 32'd2, 1'b0);
                                              step(CMD, 2'd1, 32'd3, 1'b0);
                                              step(CMD, 2'd1, 32'd4, 1'b0);
                                              step(CMD, 2'd1, 32'd5, 1'b0);
        md_done = 1'b1;                       step(CMD, 2'd1, 32'd6, 1'b0);
                                              step(C0,  2'd0, 32'd7, 1'b0);

        // Zero-latency mul/div.
        ex_md_start = 1'b1; md_done = 1'b1;   step(C0,  2'd0, 32'd7, 1'b0);
                                              step(C0,  2'd0, 32'd7, 1'b0);

        // MD_WAIT interrupted by a memory wait; md_done arrives meanwhile.
        ex_md_start = 1'b1;                   step(CMD,  2'd0, 32'd7,  1'b0);
                                              step(CMD,  2'd1, 32'd8,  1'b0);
        mem_req = 1'b1;                       step(CMEM, 2'd1, 32'd9,  1'b0);
        mem_req = 1'b1; md_done = 1'b1;       step(CMEM, 2'd2, 32'd10, 1'b0);
        mem_req = 1'b1;                       step(CMEM, 2'd2, 32'd11, 1'b0);
        mem_req = 1'b1; mem_ready = 1'b1;     step(CMEM, 2'd2, 32'd12, 1'b0);
                                              step(C0,   2'd0, 32'd13, 1'b0);

        // Same, without md_done: control returns to MD_WAIT.
        ex_md_start = 1'b1;                   step(CMD,  2'd0, 32'd13, 1'b0);
                                              step(CMD,  2'd1, 32'd14, 1'b0);
        mem_req = 1'b1;                       step(CMEM, 2'd1, 32'd15, 1'b0);
        mem_req = 1'b1;                       step(CMEM, 2'd2, 32'd16, 1'b0);
        mem_req = 1'b1;                       step(CMEM, 2'd2, 32'd17, 1'b0);
        mem_req = 1'b1; mem_ready = 1'b1;     step(CMEM, 2'd2, 32'd18, 1'b0);
                                              step(CMD,  2'd1, 32'd19, 1'b0);
        md_done = 1'b1;                       step(CMD,  2'd1, 32'd20, 1'b0);
                                              step(C0,   2'd0, 32'd21, 1'b0);

        // Plain memory wait from RUN returns to RUN.
        mem_req = 1'b1;                       step(CMEM, 2'd0, 32'd21, 1'b0);
        mem_req = 1'b1; mem_ready = 1'b1;     step(CMEM, 2'd2, 32'd22, 1'b0);
                                              step(C0,   2'd0, 32'd23, 1'b0);

        // Watchdog: 64 cycles in MD_WAIT without md_done.
        ex_md_start = 1'b1;                   step(CMD, 2'd0, 32'd23, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            step(CMD, 2'd1, 32'(23 + k), 1'b0);
        end
                                              step(C0,  2'd0, 32'd88, 1'b1);
                                              step(C0,  2'd0, 32'd88, 1'b1);

        // Reset in the middle of an MD stall clears everything at once.
        ex_md_start = 1'b1;                   step(CMD, 2'd0, 32'd88, 1'b1);
                                              step(CMD, 2'd1, 32'd89, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl",   -2, 32'(ctl_now()), 32'(C0));
        chk("mid_rst_state", -2, 32'(state_o),   32'd0);
        chk("mid_rst_cnt",   -2, stall_cnt,      32'd0);
        chk("mid_rst_err",   -2, 32'(err),       32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
                                              step(C0,  2'd0, 32'd0, 1'b0);

        // Illegal start-with-branch: MD stall wins, err becomes sticky.
        ex_md_start = 1'b1; ex_branch_taken = 1'b1;
                                              step(CMD, 2'd0, 32'd0, 1'b0);
                                              step(CMD, 2'd1, 32'd1, 1'b1);
        md_done = 1'b1;                       step(CMD, 2'd1, 32'd2, 1'b1);
                                              step(C0,  2'd0, 32'd3, 1'b1);

        repeat (3) @(negedge clk);
        chk("drain", -3, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core's pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Handles three events: load-use hazards, taken-branch redirects, and multi-cycle stalls from the mul/div unit and the data-memory handshake.
- Drives each pipeline register's en (hold) and clr (bubble) inputs. A pipeline register loads when its en=0, holds when en=1, and zeroes synchronously when clr=1; clr has priority over en.
- A 3-state FSM tracks outstanding long stalls. A watchdog and a stall performance counter are included.

Parameters:
- RA_W, 5, register-address width.
- MD_TIMEOUT, 64, maximum cycles in MD_WAIT before the watchdog fires (>=2).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2
- ex_rd  in  RA_W  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_branch_taken  in  1  EX resolves a taken branch or jump; PC loads the target
- ex_md_start  in  1  the EX instruction is a mul/div and is valid
- md_done  in  1  mul/div result ready (1-cycle pulse)
- mem_req  in  1  the MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- stall_pc  out  1  PC hold
- en_ifid, en_idex, en_exmem, en_memwb  out  1  pipeline register hold (1 = hold)
- clr_ifid, clr_idex, clr_exmem, clr_memwb  out  1  pipeline register bubble
- state_o  out  2  current FSM state: RUN=0, MD_WAIT=1, MEM_WAIT=2
- stall_cnt  out  CNT_W  count of cycles with stall_pc=1; saturates at all-ones
- err  out  1  sticky: watchdog timeout or illegal input combination

Behaviour:
- **Reset (rst=0):**
  - Asynchronous: state=RUN, md_pend=0, md_cnt=0, stall_cnt=0, err=0.
  - All en_*/clr_*/stall_pc outputs forced to 0 while rst=0.
- **Output timing:** all control outputs are Mealy (combinational from current state and inputs), so a hazard is resolved in the same cycle it appears. The state, counters and flags update on posedge clk.
- **Load-use term:** lu = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- **memw term:** memw = mem_req & ~mem_ready.
- **Output priority, highest first:**
  1. state MEM_WAIT or memw:
     - stall_pc=1; en_ifid, en_idex, en_exmem = 1; clr_memwb=1.
     - Next state: MEM_WAIT if memw, otherwise the exit rule below.
  2. state MD_WAIT, or (RUN & ex_md_start & ~md_done):
     - stall_pc=1; en_ifid, en_idex = 1; clr_exmem=1; MEM/WB flows.
     - Next state: MD_WAIT unless md_done is 1 this cycle.
  3. RUN & ex_branch_taken:
     - clr_ifid=1, clr_idex=1; stall_pc=0.
     - Any simultaneous lu is ignored (wrong-path instruction).
  4. RUN & lu:
     - stall_pc=1, en_ifid=1, clr_idex=1.
     - Exactly one bubble is inserted; the next cycle lu is 0 because EX now holds the bubble.
  5. Otherwise all outputs are 0.
- **MD_WAIT exit:** md_done=1 releases the stall in that same cycle; next state=RUN.
- **md_done during MEM_WAIT:**
  - md_done=1 while in MEM_WAIT sets md_pend, so the pulse is not lost.
  - When memw falls: next state=RUN if md_pend, or if MEM_WAIT was entered from RUN without an MD op pending. Otherwise next state=MD_WAIT.
  - md_pend clears on leaving MEM_WAIT.
  - MEM_WAIT entered from MD_WAIT returns to MD_WAIT.
- **Watchdog:**
  - md_cnt increments each cycle in MD_WAIT and is cleared otherwise.
  - When md_cnt reaches MD_TIMEOUT-1 with md_done=0: err is set, the FSM is forced to RUN, and the stall is released the following cycle.
- **Illegal input:** ex_md_start & ex_branch_taken in the same cycle sets err; the MD stall takes priority.
- **err** is cleared only by reset.
- **stall_cnt** increments on every cycle with stall_pc=1 and holds at 2^CNT_W-1.
- **Zero-latency mul/div:** ex_md_start & md_done in the same cycle causes no stall.

Test Plan:
1. **Load-use:** ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with stall_pc=1, en_ifid=1, clr_idex=1; next cycle all outputs 0; stall_cnt=1.
2. **x0 and branch priority:** ex_rd=0 with a matching rs1 -> no stall. Then ex_branch_taken together with a load-use match -> clr_ifid=1, clr_idex=1, stall_pc=0.
3. **Mul/div stall:** ex_md_start with md_done 4 cycles later -> state_o=1 for 4 cycles; stall_pc, en_ifid, en_idex, clr_exmem = 1 for 5 cycles including the start cycle; release in the md_done cycle; stall_cnt=5.
4. **Overlapping waits:**
   - Sequence: MD_WAIT, then mem_req=1 & mem_ready=0 for 3 cycles, with md_done pulsing in the 2nd of those cycles.
   - Required: state_o=2 for 3 cycles with clr_memwb=1; after mem_ready, RUN with no further MD stall.
   - Repeat without the md_done pulse -> state returns to MD_WAIT.
5. **Watchdog:** ex_md_start and no md_done -> after MD_TIMEOUT=64 cycles, err=1 and state_o=0; err stays 1 until rst.
6. **Reset mid-stall:** rst=0 in MD_WAIT -> all outputs, state_o, stall_cnt and err read 0 immediately, with no clock edge needed.
